// File: rtl/cr16_alu_core.sv
// CR16 ALU core: single-cycle registered arithmetic/logic unit with status flags.
// Define CR16_ALU_SHIFTS_EN to build the shifter for opcodes 10-13.
module cr16_alu_core (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_ENABLE,
  input  logic [3:0]  I_OPCODE,
  input  logic [15:0] I_A,
  input  logic [15:0] I_B,
  output logic [15:0] O_C,
  output logic [4:0]  O_STATUS
);

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 5;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_ADDC  = 4'd2;
  localparam logic [3:0] OP_ADDCU = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_SUBU  = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
`ifdef CR16_ALU_SHIFTS_EN
  localparam logic [3:0] OP_LSH   = 4'd10;
  localparam logic [3:0] OP_RSH   = 4'd11;
  localparam logic [3:0] OP_ALSH  = 4'd12;
  localparam logic [3:0] OP_ARSH  = 4'd13;
`endif

  logic [W-1:0]  c_q, c_d;
  logic [SW-1:0] st_q, st_d;

  logic [W:0]    sum;
  logic [W-1:0]  diff;
  logic          cin;
  logic          add_ovf;
  logic          sub_ovf;
  logic          borrow;
  logic          n_f, z_f, f_f, l_f, c_f;

`ifdef CR16_ALU_SHIFTS_EN
  logic          sh_big;
  logic [W-1:0]  shl, shr, sar;

  // Amounts of 16 or more saturate; only the low nibble drives the barrel.
  always_comb begin
    sh_big = |I_B[W-1:4];
    shl    = sh_big ? '0 : (I_A << I_B[3:0]);
    shr    = sh_big ? '0 : (I_A >> I_B[3:0]);
    sar    = sh_big ? {W{I_A[W-1]}} : W'($signed(I_A) >>> I_B[3:0]);
  end
`endif

  // Shared adder/subtractor and flag sources.
  always_comb begin
    cin     = (I_OPCODE == OP_ADDC) || (I_OPCODE == OP_ADDCU);
    sum     = {1'b0, I_A} + {1'b0, I_B} + (W+1)'(cin);
    diff    = I_B - I_A;
    borrow  = I_B < I_A;
    add_ovf = (I_A[W-1] == I_B[W-1]) && (sum[W-1] != I_A[W-1]);
    sub_ovf = (I_A[W-1] != I_B[W-1]) && (diff[W-1] != I_B[W-1]);
  end

  // Result mux and status assembly {N,Z,F,L,C}.
  always_comb begin
    c_d = '0;
    n_f = 1'b0;
    f_f = 1'b0;
    l_f = 1'b0;
    c_f = 1'b0;
    case (I_OPCODE)
      OP_ADD, OP_ADDC: begin
        c_d = sum[W-1:0];
        f_f = add_ovf;
        n_f = sum[W-1];
      end
      OP_ADDU, OP_ADDCU: begin
        c_d = sum[W-1:0];
        c_f = sum[W];
      end
      OP_SUB: begin
        c_d = diff;
        f_f = sub_ovf;
        n_f = diff[W-1];
      end
      OP_SUBU: begin
        c_d = diff;
        c_f = borrow;
        l_f = borrow;
      end
      OP_AND: begin c_d = I_A & I_B; n_f = c_d[W-1]; end
      OP_OR:  begin c_d = I_A | I_B; n_f = c_d[W-1]; end
      OP_XOR: begin c_d = I_A ^ I_B; n_f = c_d[W-1]; end
      OP_NOT: begin c_d = ~I_A;      n_f = c_d[W-1]; end
`ifdef CR16_ALU_SHIFTS_EN
      OP_LSH, OP_ALSH: begin c_d = shl; n_f = c_d[W-1]; end
      OP_RSH:          begin c_d = shr; n_f = c_d[W-1]; end
      OP_ARSH:         begin c_d = sar; n_f = c_d[W-1]; end
`endif
      default: c_d = '0;
    endcase
    z_f  = (c_d == '0);
    st_d = {n_f, z_f, f_f, l_f, c_f};
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      c_q  <= '0;
      st_q <= '0;
    end else if (I_ENABLE) begin
      c_q  <= c_d;
      st_q <= st_d;
    end
  end

  assign O_C      = c_q;
  assign O_STATUS = st_q;

endmodule

// File: tb/tb_cr16_alu_core.sv
// Randomized self-checking bench for cr16_alu_core against an integer-arithmetic model.
module tb_cr16_alu_core;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [4:0]  st;

  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q;

  cr16_alu_core dut (
    .I_CLK    (clk),
    .I_RESET  (rst),
    .I_ENABLE (en),
    .I_OPCODE (op),
    .I_A      (a),
    .I_B      (b),
    .O_C      (c),
    .O_STATUS (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got st=%b c=%h exp st=%b c=%h", tag, got[20:16], got[15:0],
               expv[20:16], expv[15:0]);
    end
  endtask

  // Returns {N,Z,F,L,C, result} from plain integer arithmetic.
  function automatic logic [20:0] ref_alu(input logic [3:0] o, input logic [15:0] x,
                                          input logic [15:0] y);
    int sx, sy, ux, uy, r;
    logic [15:0] res;
    logic cf, lf, ff, nf, signed_op;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    r  = 0;
    cf = 1'b0; lf = 1'b0; ff = 1'b0;
    signed_op = 1'b1;
    case (o)
      4'd0: begin r = sx + sy;     ff = (r > 32767) || (r < -32768); end
      4'd1: begin r = ux + uy;     cf = (r > 65535); signed_op = 1'b0; end
      4'd2: begin r = sx + sy + 1; ff = (r > 32767) || (r < -32768); end
      4'd3: begin r = ux + uy + 1; cf = (r > 65535); signed_op = 1'b0; end
      4'd4: begin r = sy - sx;     ff = (r > 32767) || (r < -32768); end
      4'd5: begin r = uy - ux;     cf = (uy < ux); lf = cf; signed_op = 1'b0; end
      4'd6: r = int'(x & y);
      4'd7: r = int'(x | y);
      4'd8: r = int'(x ^ y);
      4'd9: r = int'(~x);
`ifdef CR16_ALU_SHIFTS_EN
      4'd10, 4'd12: r = (uy >= 16) ? 0 : ux * (1 << uy);
      4'd11:        r = (uy >= 16) ? 0 : ux / (1 << uy);
      4'd13:        r = (uy >= 16) ? ((sx < 0) ? -1 : 0) : (sx >>> uy);
`endif
      default: begin r = 0; signed_op = 1'b0; end
    endcase
    res = r[15:0];
    nf  = signed_op & res[15];
    return {nf, (res == 16'h0000), ff, lf, cf, res};
  endfunction

  // Apply one operation; sample one time unit after the edge and track expectation.
  task automatic step(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic e, input string tag);
    @(negedge clk);
    op = o; a = x; b = y; en = e;
    if (e) exp_q = ref_alu(o, x, y);
    @(posedge clk);
    #1;
    check_eq(tag, {st, c}, exp_q);
  endtask

  logic [20:0] shexp;

  initial begin
    rst = 1'b1; en = 1'b1; op = 4'd0; a = 16'h1234; b = 16'h4321;
    exp_q = '0;
    #1;
    check_eq("reset_async", {st, c}, 21'h0);
    @(posedge clk); #1;
    check_eq("reset_held", {st, c}, 21'h0);
    @(negedge clk); rst = 1'b0;

    step(4'd0, 16'h7FFF, 16'h0001, 1'b1, "add_ovf");
    check_eq("add_ovf_k", {st, c}, {5'b10100, 16'h8000});
    step(4'd1, 16'hFFFF, 16'h0001, 1'b1, "addu_carry");
    check_eq("addu_carry_k", {st, c}, {5'b01001, 16'h0000});
    step(4'd3, 16'hFFFF, 16'h0000, 1'b1, "addcu_carry");
    check_eq("addcu_carry_k", {st, c}, {5'b01001, 16'h0000});
    step(4'd5, 16'h0005, 16'h0003, 1'b1, "subu_borrow");
    check_eq("subu_borrow_k", {st, c}, {5'b00011, 16'hFFFE});
    step(4'd5, 16'h0003, 16'h0003, 1'b1, "subu_zero");
    check_eq("subu_zero_k", {st, c}, {5'b01000, 16'h0000});
    step(4'd4, 16'h0001, 16'h8000, 1'b1, "sub_ovf");
    check_eq("sub_ovf_k", {st, c}, {5'b00100, 16'h7FFF});
    step(4'd4, 16'h0002, 16'h0005, 1'b1, "sub_plain");
    check_eq("sub_plain_k", {st, c}, {5'b00000, 16'h0003});

    step(4'd13, 16'h8000, 16'h0004, 1'b1, "arsh");
`ifdef CR16_ALU_SHIFTS_EN
    shexp = {5'b10000, 16'hF800};
`else
    shexp = {5'b01000, 16'h0000};
`endif
    check_eq("arsh_k", {st, c}, shexp);
    step(4'd11, 16'h8000, 16'h0004, 1'b1, "rsh");
`ifdef CR16_ALU_SHIFTS_EN
    shexp = {5'b00000, 16'h0800};
`else
    shexp = {5'b01000, 16'h0000};
`endif
    check_eq("rsh_k", {st, c}, shexp);
    step(4'd10, 16'h0001, 16'h0010, 1'b1, "lsh16");
    check_eq("lsh16_k", {st, c}, {5'b01000, 16'h0000});
    step(4'd14, 16'hABCD, 16'h1234, 1'b1, "op14");
    check_eq("op14_k", {st, c}, {5'b01000, 16'h0000});

    // Hold with enable low while inputs move.
    step(4'd7, 16'h8001, 16'h0100, 1'b1, "or_pre_hold");
    step(4'd0, 16'h1111, 16'h2222, 1'b0, "hold1");
    step(4'd9, 16'h0000, 16'h0000, 1'b0, "hold2");
    check_eq("hold_k", {st, c}, {5'b10000, 16'h8101});

    // Reset pulse mid-cycle clears outputs before the next edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("reset_mid", {st, c}, 21'h0);
    @(posedge clk); #1;
    check_eq("reset_mid_held", {st, c}, 21'h0);
    exp_q = '0;
    @(negedge clk); rst = 1'b0;
    step(4'd8, 16'hF0F0, 16'h0FF0, 1'b1, "post_reset");

    for (int i = 0; i < 400; i++) begin
      logic [15:0] rb;
      rb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      step(4'($urandom_range(0, 15)), 16'($urandom), rb,
           ($urandom_range(0, 3) != 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
